// File: rtl/rr_arbiter_n_hold.sv
// rr_arbiter_n_hold: N-requester round-robin arbiter with registered one-hot
// grant that stays locked on the winner until it pulses done or drops req.
// Optional hold limit: define RR_ARB_HOLD_LIMIT_EN to force a release after
// MAX_HOLD granted cycles. With the macro undefined a holder may keep its grant
// forever, and MAX_HOLD is only range-checked.
module rr_arbiter_n_hold #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;        // highest-priority requester at next arbitration
  logic           expire;     // forced release from the hold limit
  logic           excl;       // holder must not win the release arbitration
  logic           release_c;  // current holder gives up the grant this edge
  logic [N-1:0]   cand;
  logic           found;
  logic [IDW-1:0] win;
  logic [N-1:0]   win_oh;
  logic [IDW-1:0] ptr_nxt;

  // Elaboration-time parameter range check
  if (N < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_arbiter_n_hold: need N >= 2 and MAX_HOLD >= 1");
  end

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt;

  // The last granted cycle of the allowance is the one where cnt = MAX_HOLD-1
  assign expire = (state == BUSY) && (hold_cnt == CW'(MAX_HOLD - 1));

  // Count granted cycles of the current holder; restart on every new grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               hold_cnt <= '0;
    else if (state == IDLE || release_c)   hold_cnt <= '0;
    else                                   hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  assign excl      = done[gnt_id] | expire;
  assign release_c = (state == BUSY) && (excl || !req[gnt_id]);

  // Candidate set: on a done/forced release the holder sits out this round
  always_comb begin
    cand = req;
    if (state == BUSY && excl) cand[gnt_id] = 1'b0;
  end

  // Search cand from ptr upward with wrap; ptr already points past the holder
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && cand[j]) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
  end

  // One-hot form of the winner and the pointer value that follows it
  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
    ptr_nxt     = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
  end

  // Grant state: take a winner from IDLE, or hand over / drop on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= BUSY;
            gnt       <= win_oh;
            gnt_id    <= win;
            gnt_valid <= 1'b1;
            ptr       <= ptr_nxt;
          end
        end
        BUSY: begin
          if (release_c) begin
            if (found) begin
              gnt       <= win_oh;
              gnt_id    <= win;
              gnt_valid <= 1'b1;
              ptr       <= ptr_nxt;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
